griffin_li_layer: RTL and testbench
===================================

GRIFFIN_LI_LAYER -- requirements
Module: griffin_li_layer

Interface
REQ-001 Parameter N_BITS, default 254, SHALL set the field element width.
REQ-002 Parameter PRIME_MODULUS, default 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, SHALL set the field modulus p.
REQ-003 Parameter NUM_TERMS, default 10, range 1..31, SHALL set the number of terms K generated per job.
REQ-004 Localparam IDX_W = $clog2(NUM_TERMS+1) SHALL set the term index width.
REQ-005 Port clk, input, 1 bit: sole clock, rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port start_valid, input, 1 bit: a job request is present.
REQ-008 Port start_ready, output, 1 bit: a job can be accepted.
REQ-009 Port y0, input, N_BITS: job coefficient, sampled on start handshake.
REQ-010 Port y1, input, N_BITS: job offset, sampled on start handshake.
REQ-011 Port x_valid, input, 1 bit: an x term is present.
REQ-012 Port x_ready, output, 1 bit: an x term can be accepted.
REQ-013 Port x_in, input, N_BITS: term x_k, supplied in order k=1..K.
REQ-014 Port l_valid, output, 1 bit: a result is present.
REQ-015 Port l_ready, input, 1 bit: the consumer accepts the result.
REQ-016 Port l_out, output, N_BITS: the result l_k.
REQ-017 Port l_idx, output, IDX_W: the index k of l_out.
REQ-018 Port l_last, output, 1 bit: asserted when l_idx == K.
REQ-019 Port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-020 For each k in 1..K, the block SHALL produce l_k = (k*y0 + y1 + x_k) mod p; inputs are canonical (< p) and l_out SHALL be canonical.
REQ-021 k*y0 SHALL be formed incrementally by an accumulator acc, with no multiplier.
- On job start, acc <= y0.
- On each accepted x, acc <= (acc + y0) mod p, using one conditional subtraction of p.
REQ-022 The three-input sum SHALL be reduced mod p with up to two conditional subtractions (sum < 3p).
REQ-023 The FSM SHALL have three states.
- IDLE: start_ready=1. start_valid&start_ready latches y0 and y1, sets k=1 and moves to RUN.
- RUN: accepts x terms. Acceptance of term K moves to DRAIN.
- DRAIN: moves to IDLE on the handshake of the l_last result.
REQ-024 x_ready SHALL be 1 only in RUN and only when (!l_valid || l_ready).
REQ-025 A result SHALL be registered one cycle after x acceptance (latency 1), and l_valid SHALL rise in that cycle.
REQ-026 Throughput SHALL be one term per cycle when l_ready is held high, with no bubbles.
REQ-027 While l_valid && !l_ready, l_out, l_idx and l_last SHALL hold stable.
REQ-028 l_valid SHALL clear on handshake unless a new x is accepted in the same cycle.
REQ-029 start_valid SHALL be ignored outside IDLE (start_ready=0), and y0/y1 changes during a job SHALL have no effect.
REQ-030 x_valid SHALL be ignored outside RUN.
REQ-031 The next job MAY be started in the cycle after the DRAIN-to-IDLE transition.

Reset
REQ-032 Asserting rst_n low SHALL asynchronously force the following, including mid-job; no partial job SHALL resume.
- FSM to IDLE.
- l_valid, l_last and busy to 0.
- l_out, l_idx, acc, the k counter and the latched y0/y1 to 0.
REQ-033 With rst_n low, start_ready SHALL read 1 and x_ready SHALL read 0, as combinational functions of state.

Structure
REQ-034 The FSM state enum and the default modulus SHALL live in shared package griffin_pkg.
REQ-035 The modular adder SHALL be one sub-module, griffin_mod_add: 2- or 3-operand, parameterised by N_BITS and PRIME_MODULUS, combinational.
REQ-036 Two instances of griffin_mod_add SHALL be used: the accumulator update and the output sum.

Verification
REQ-037 Basic: K=4, y0=2, y1=3, x_k=k -> l_out 6, 9, 12, 15, l_idx 1..4, l_last only on the 4th.
REQ-038 Wrap: y0=p-1, y1=0, x_k=0 -> l_k = p-k for all k, all < p.
REQ-039 Maximum operands: y0=y1=x_1=p-1 -> l_1 = p-3.
REQ-040 Backpressure: l_ready low for 3 cycles after the first result.
- l_out and l_idx stay stable and x_ready stays 0.
- On release, the stream completes in order with no loss or duplication.
REQ-041 Protocol: start_valid pulsed during RUN is ignored and the result stream is unchanged.
REQ-042 Reset: rst_n pulsed low after 2 of K=4 terms.
- All outputs clear immediately.
- A new job afterwards produces the correct l_1..l_4.

Source files
------------

// File: rtl/griffin_pkg.sv
// ============================================================================
// griffin_pkg : shared FSM state type and default field modulus
// Rev 1.0
// ============================================================================
`default_nettype none

package griffin_pkg;

    // BN254 scalar field modulus
    localparam logic [253:0] GRIFFIN_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } griffin_state_t;

endpackage

`default_nettype wire

// File: rtl/griffin_mod_add.sv
// ============================================================================
// griffin_mod_add : combinational 2- or 3-operand adder modulo PRIME_MODULUS
// Rev 1.0
// ============================================================================
`default_nettype none

module griffin_mod_add
    import griffin_pkg::*;
#(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = N_BITS'(GRIFFIN_MODULUS),
    parameter int                N_OPS         = 3
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [N_BITS-1:0] c,
    output logic [N_BITS-1:0] sum
);

    localparam logic [N_BITS+1:0] P_EXT = {2'b00, PRIME_MODULUS};

    logic [N_BITS+1:0] raw;
    logic [N_BITS+1:0] once;
    logic [N_BITS+1:0] twice;

    // Two-operand users tie c to zero, so the sum stays below 2p there
    assign raw  = {2'b00, a} + {2'b00, b} + {2'b00, c};
    assign once = (raw >= P_EXT) ? (raw - P_EXT) : raw;

    generate
        if (N_OPS == 3) begin : g_two_sub
            assign twice = (once >= P_EXT) ? (once - P_EXT) : once;
        end else begin : g_one_sub
            assign twice = once;
        end
    endgenerate

    assign sum = N_BITS'(twice);

endmodule

`default_nettype wire

// File: rtl/griffin_li_layer.sv
// ============================================================================
// griffin_li_layer : streams l_k = (k*y0 + y1 + x_k) mod p for k = 1..K
// Rev 1.0
// ============================================================================
`default_nettype none

module griffin_li_layer
    import griffin_pkg::*;
#(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = N_BITS'(GRIFFIN_MODULUS),
    parameter int                NUM_TERMS     = 10,
    localparam int               IDX_W         = $clog2(NUM_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [N_BITS-1:0] y0,
    input  logic [N_BITS-1:0] y1,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [N_BITS-1:0] x_in,
    output logic              l_valid,
    input  logic              l_ready,
    output logic [N_BITS-1:0] l_out,
    output logic [IDX_W-1:0]  l_idx,
    output logic              l_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_TERMS);

    griffin_state_t    state;
    logic [N_BITS-1:0] acc;
    logic [N_BITS-1:0] y0_q;
    logic [N_BITS-1:0] y1_q;
    logic [IDX_W-1:0]  k;
    logic [N_BITS-1:0] acc_next;
    logic [N_BITS-1:0] sum_mod;
    logic              x_fire;
    logic              l_fire;

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign x_ready     = (state == ST_RUN) && (!l_valid || l_ready);
    assign x_fire      = x_valid && x_ready;
    assign l_fire      = l_valid && l_ready;

    // acc always holds k*y0 mod p for the term about to be accepted
    griffin_mod_add #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS),
        .N_OPS         (2)
    ) u_acc_add (
        .a   (acc),
        .b   (y0_q),
        .c   ({N_BITS{1'b0}}),
        .sum (acc_next)
    );

    griffin_mod_add #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS),
        .N_OPS         (3)
    ) u_out_add (
        .a   (acc),
        .b   (y1_q),
        .c   (x_in),
        .sum (sum_mod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            k       <= '0;
            l_valid <= 1'b0;
            l_out   <= '0;
            l_idx   <= '0;
            l_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        y0_q  <= y0;
                        y1_q  <= y1;
                        acc   <= y0;
                        k     <= IDX_W'(1);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (x_fire) begin
                        acc <= acc_next;
                        k   <= k + IDX_W'(1);
                        if (k == K_LAST) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (l_fire && l_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new acceptance in the handshake cycle keeps l_valid high
            if (x_fire) begin
                l_valid <= 1'b1;
                l_out   <= sum_mod;
                l_idx   <= k;
                l_last  <= (k == K_LAST);
            end else if (l_fire) begin
                l_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_griffin_li_layer.sv
// ============================================================================
// tb_griffin_li_layer : directed self-checking bench for griffin_li_layer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_griffin_li_layer;

    localparam int W = 254;
    localparam int K = 4;
    localparam logic [W-1:0] P =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic         x_valid;
    logic         x_ready;
    logic [W-1:0] x_in;
    logic         l_valid;
    logic         l_ready;
    logic [W-1:0] l_out;
    logic [2:0]   l_idx;
    logic         l_last;
    logic         busy;

    logic [W-1:0] xv [K];
    logic [W-1:0] ev [K];

    int n_checks = 0;
    int n_pass   = 0;

    griffin_li_layer #(
        .N_BITS        (W),
        .PRIME_MODULUS (P),
        .NUM_TERMS     (K)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .y0          (y0),
        .y1          (y1),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_in        (x_in),
        .l_valid     (l_valid),
        .l_ready     (l_ready),
        .l_out       (l_out),
        .l_idx       (l_idx),
        .l_last      (l_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " l_valid"},     256'(l_valid),     256'(0));
        check({tag, " l_out"},       256'(l_out),       256'(0));
        check({tag, " l_idx"},       256'(l_idx),       256'(0));
        check({tag, " l_last"},      256'(l_last),      256'(0));
        check({tag, " busy"},        256'(busy),        256'(0));
        check({tag, " start_ready"}, 256'(start_ready), 256'(1));
        check({tag, " x_ready"},     256'(x_ready),     256'(0));
    endtask

    // Runs one K-term job from xv/ev; optionally stalls after the first result
    // and/or pokes start_valid while the job is running.
    task automatic do_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit poke);
        @(negedge clk);
        start_valid = 1'b1;
        y0 = a;
        y1 = b;
        #1 check({tag, " start_ready"}, 256'(start_ready), 256'(1));
        @(negedge clk);
        start_valid = 1'b0;
        y0 = ~a;
        y1 = ~b;
        check({tag, " busy"}, 256'(busy), 256'(1));
        for (int i = 0; i < K; i++) begin
            x_valid = 1'b1;
            x_in    = xv[i];
            start_valid = poke && (i == 1);
            #1 check($sformatf("%s x_ready%0d", tag, i + 1), 256'(x_ready), 256'(1));
            @(negedge clk);
            start_valid = 1'b0;
            check($sformatf("%s l_valid%0d", tag, i + 1), 256'(l_valid), 256'(1));
            check($sformatf("%s l_out%0d", tag, i + 1),   256'(l_out),   256'(ev[i]));
            check($sformatf("%s l_idx%0d", tag, i + 1),   256'(l_idx),   256'(i + 1));
            check($sformatf("%s l_last%0d", tag, i + 1),  256'(l_last),  256'(i == K - 1));
            if (i == 0 && stall > 0) begin
                l_ready = 1'b0;
                x_in    = xv[1];
                for (int s = 0; s < stall; s++) begin
                    #1 check($sformatf("%s stall x_ready%0d", tag, s), 256'(x_ready), 256'(0));
                    @(negedge clk);
                    check($sformatf("%s stall l_out%0d", tag, s), 256'(l_out), 256'(ev[0]));
                    check($sformatf("%s stall l_idx%0d", tag, s), 256'(l_idx), 256'(1));
                end
                l_ready = 1'b1;
            end
        end
        x_valid = 1'b0;
        x_in    = '0;
        @(negedge clk);
        check({tag, " end l_valid"},     256'(l_valid),     256'(0));
        check({tag, " end busy"},        256'(busy),        256'(0));
        check({tag, " end start_ready"}, 256'(start_ready), 256'(1));
    endtask

    task automatic set_basic();
        for (int i = 0; i < K; i++) begin
            xv[i] = W'(i + 1);
            ev[i] = W'(6 + 3 * i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        y0 = '0;
        y1 = '0;
        x_valid = 1'b0;
        x_in = '0;
        l_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        set_basic();
        do_job("basic", W'(2), W'(3), 0, 1'b0);

        for (int i = 0; i < K; i++) begin
            xv[i] = '0;
            ev[i] = P - W'(i + 1);
        end
        do_job("wrap", P - 1, '0, 0, 1'b0);

        xv[0] = P - 1;  xv[1] = '0;     xv[2] = '0;     xv[3] = '0;
        ev[0] = P - 3;  ev[1] = P - 3;  ev[2] = P - 4;  ev[3] = P - 5;
        do_job("maxop", P - 1, P - 1, 0, 1'b0);

        xv[0] = P - 1;  xv[1] = W'(7);  xv[2] = '0;     xv[3] = P - 2;
        ev[0] = W'(3);  ev[1] = W'(16); ev[2] = W'(14); ev[3] = W'(17);
        do_job("mixed", W'(5), P - 1, 0, 1'b0);

        set_basic();
        do_job("bp", W'(2), W'(3), 3, 1'b0);
        do_job("proto", W'(2), W'(3), 0, 1'b1);

        // Abort a job after two terms with an asynchronous reset
        @(negedge clk);
        start_valid = 1'b1;
        y0 = W'(2);
        y1 = W'(3);
        @(negedge clk);
        start_valid = 1'b0;
        x_valid = 1'b1;
        x_in = W'(1);
        @(negedge clk);
        x_in = W'(2);
        @(negedge clk);
        x_valid = 1'b0;
        check("rst_mid l_idx", 256'(l_idx), 256'(2));
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_mid");
        #1 rst_n = 1'b1;
        do_job("after_rst", W'(2), W'(3), 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
